// File: rtl/cpu2wb_byte_pkg.sv
// Shared definitions for the CPU-to-byte-Wishbone bridge: FSM encoding and lane constants.
package cpu2wb_byte_pkg;

    localparam int          NLANE    = 4;
    localparam int          LANE_W   = $clog2(NLANE);
    localparam logic [7:0]  ERR_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/cpu2wb_byte_if.sv
// Single-byte Wishbone bus between the bridge (master) and a register slave.
interface cpu2wb_byte_if #(
    parameter int ASIZE = 2,
    parameter int DSIZE = 8
) ();
    logic [ASIZE-1:0] adr;
    logic             stb;
    logic             we;
    logic [DSIZE-1:0] dat_w;
    logic             ack;
    logic [DSIZE-1:0] dat_r;

    modport master (output adr, stb, we, dat_w, input ack, dat_r);
    modport slave  (input adr, stb, we, dat_w, output ack, dat_r);
endinterface

// File: rtl/cpu2wb_byte_lane_pick.sv
// Find-first-set over the pending-lane mask; lowest lane wins so lanes go out in ascending order.
module cpu2wb_byte_lane_pick
    import cpu2wb_byte_pkg::*;
(
    input  logic [NLANE-1:0]  i_mask,
    output logic              o_valid,
    output logic [LANE_W-1:0] o_idx
);
    always_comb begin
        o_valid = |i_mask;
        o_idx   = '0;
        if      (i_mask[0]) o_idx = 2'd0;
        else if (i_mask[1]) o_idx = 2'd1;
        else if (i_mask[2]) o_idx = 2'd2;
        else if (i_mask[3]) o_idx = 2'd3;
    end
endmodule

// File: rtl/cpu2wb_byte.sv
// Splits one 32-bit CPU access into single-byte Wishbone cycles, one lane per slave register,
// with a no-ack timeout that completes the CPU access with an error flag.
module cpu2wb_byte
    import cpu2wb_byte_pkg::*;
#(
    parameter int ASIZE   = 2,
    parameter int DSIZE   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_mem_valid,
    input  logic [31:0]   i_mem_wdata,
    input  logic [3:0]    i_mem_wstrb,
    output logic          o_mem_ready,
    output logic [31:0]   o_mem_rdata,
    output logic          o_mem_err,
    cpu2wb_byte_if.master wb
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                        r_state, w_state_nxt;
    logic [NLANE-1:0]              r_mask;
    logic [NLANE-1:0][DSIZE-1:0]   r_wdata;
    logic [NLANE-1:0][DSIZE-1:0]   r_rdata;
    logic                          r_we;
    logic                          r_err;
    logic [CW-1:0]                 r_cnt;

    logic                          w_valid;
    logic [LANE_W-1:0]             w_idx;
    logic                          w_take;
    logic                          w_tmo;
    logic                          w_stb;
    logic                          w_ready;
    logic [ASIZE-1:0]              w_adr;
    logic [DSIZE-1:0]              w_dat;

    cpu2wb_byte_lane_pick u_lane_pick (
        .i_mask  (r_mask),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default first; a missed branch would otherwise infer a latch.
        w_state_nxt = r_state;
        w_stb       = 1'b0;
        w_adr       = '0;
        w_dat       = '0;
        w_take      = 1'b0;
        w_tmo       = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: if (i_mem_valid) w_state_nxt = S_REQ;
            S_REQ: begin
                w_stb = 1'b1;
                w_adr = ASIZE'(w_idx);
                w_dat = r_we ? r_wdata[w_idx] : '0;
                // An ack arriving on the expiry cycle still wins over the timeout.
                if (wb.ack) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_GAP;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_GAP:   w_state_nxt = w_valid ? S_REQ : S_DONE;
            S_DONE: begin
                w_ready     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mask  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_cnt <= (r_state == S_REQ) ? r_cnt + CW'(1) : '0;
            if (r_state == S_IDLE && i_mem_valid) begin
                r_wdata <= i_mem_wdata;
                r_we    <= |i_mem_wstrb;
                r_mask  <= (|i_mem_wstrb) ? i_mem_wstrb : {NLANE{1'b1}};
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
            if (w_take) begin
                r_mask[w_idx] <= 1'b0;
                if (!r_we) r_rdata[w_idx] <= wb.dat_r;
            end
            if (w_tmo) begin
                r_err  <= 1'b1;
                r_mask <= '0;
                for (int i = 0; i < NLANE; i++) begin
                    if (!r_we && r_mask[i]) r_rdata[i] <= DSIZE'(ERR_BYTE);
                end
            end
        end
    end

    assign wb.stb      = w_stb;
    assign wb.adr      = w_adr;
    assign wb.we       = w_stb & r_we;
    assign wb.dat_w    = w_dat;
    assign o_mem_ready = w_ready;
    assign o_mem_rdata = r_rdata;
    assign o_mem_err   = r_err;
endmodule

// File: tb/tb_cpu2wb_byte.sv
// Directed and randomized checks of cpu2wb_byte against a lane-level reference model and a stub slave.
module tb_cpu2wb_byte;
    import cpu2wb_byte_pkg::*;

    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic       we;
        logic [1:0] adr;
        logic [7:0] dat;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;

    always #5 clk = ~clk;

    cpu2wb_byte_if #(.ASIZE(2), .DSIZE(8)) wb_if ();

    cpu2wb_byte #(.ASIZE(2), .DSIZE(8), .TIMEOUT(TIMEOUT)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mem_valid (mem_valid),
        .i_mem_wdata (mem_wdata),
        .i_mem_wstrb (mem_wstrb),
        .o_mem_ready (mem_ready),
        .o_mem_rdata (mem_rdata),
        .o_mem_err   (mem_err),
        .wb          (wb_if)
    );

    // Stub register slave: ack after ack_delay strobe cycles, or never when no_ack is set.
    logic [7:0] slv_regs [4];
    logic [7:0] exp_regs [4];
    txn_t       got_q [$];
    int         ack_delay;
    bit         no_ack;
    logic       spur_ack;
    logic       r_ack;
    int         scnt;

    assign wb_if.ack   = r_ack | spur_ack;
    assign wb_if.dat_r = slv_regs[wb_if.adr];

    always @(posedge clk) begin
        if (rst) begin
            r_ack <= 1'b0;
            scnt  <= 0;
        end else if (r_ack) begin
            r_ack <= 1'b0;
            scnt  <= 0;
            if (wb_if.stb) begin
                if (wb_if.we) slv_regs[wb_if.adr] <= wb_if.dat_w;
                got_q.push_back({wb_if.we, wb_if.adr, wb_if.we ? wb_if.dat_w : slv_regs[wb_if.adr]});
            end
        end else if (wb_if.stb && !no_ack) begin
            if (scnt == ack_delay - 1) r_ack <= 1'b1;
            else                       scnt  <= scnt + 1;
        end else begin
            scnt <= 0;
        end
    end

    int   stb_cyc   = 0;
    int   stb_rise  = 0;
    int   ready_cnt = 0;
    logic prev_stb  = 1'b0;

    always @(negedge clk) begin
        if (wb_if.stb)              stb_cyc   <= stb_cyc + 1;
        if (wb_if.stb && !prev_stb) stb_rise  <= stb_rise + 1;
        if (mem_ready)              ready_cnt <= ready_cnt + 1;
        prev_stb <= wb_if.stb;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One CPU access. Expectations come from lane rules: a read visits all 4 lanes, a write only
    // strobed lanes, each lane costs (d+1) strobe cycles plus one gap, and DONE adds one more.
    task automatic do_req(input logic [31:0] wd, input logic [3:0] ws, input int d,
                          input bit tmo, input string tag);
        txn_t        exp_q [$];
        logic [31:0] exp_rd;
        bit          rd;
        int          n, lat, exp_lat, rise0, cyc0;
        rd     = (ws == 4'b0000);
        exp_rd = '0;
        if (tmo) begin
            exp_rd  = rd ? 32'hFFFF_FFFF : 32'h0;
            exp_lat = TIMEOUT + 1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rd || ws[i]) begin
                    exp_q.push_back({!rd, 2'(i), rd ? exp_regs[i] : wd[8*i +: 8]});
                    if (rd) exp_rd[8*i +: 8] = exp_regs[i];
                    else    exp_regs[i]      = wd[8*i +: 8];
                end
            end
            exp_lat = exp_q.size() * (d + 2) + 1;
        end
        n = exp_q.size();
        ack_delay = d;
        got_q.delete();
        rise0 = stb_rise;
        cyc0  = stb_cyc;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_wdata = wd;
        mem_wstrb = ws;
        @(posedge clk);
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) begin
                mem_valid = 1'b0;
                mem_wdata = $urandom;
                mem_wstrb = 4'($urandom);
            end
            if (mem_ready) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rdata"}, mem_rdata, exp_rd);
        check({tag, " err"}, {31'b0, mem_err}, {31'b0, tmo});
        @(negedge clk);
        check({tag, " ready one-cycle"}, {31'b0, mem_ready}, 32'h0);
        @(posedge clk);
        #1;
        check({tag, " wb cycle count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            check({tag, " wb cycle"}, {15'b0, got_q[i]}, {15'b0, exp_q[i]});
        check({tag, " stb bursts"}, stb_rise - rise0, tmo ? 1 : n);
        check({tag, " stb cycles"}, stb_cyc - cyc0, tmo ? TIMEOUT : n * (d + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        int          r0, c0, found;
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_wdata = '0;
        mem_wstrb = '0;
        spur_ack  = 1'b0;
        no_ack    = 1'b0;
        ack_delay = 1;
        for (int i = 0; i < 4; i++) begin
            slv_regs[i] = '0;
            exp_regs[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset stb",   {31'b0, wb_if.stb}, 32'h0);
        check("reset ready", {31'b0, mem_ready}, 32'h0);
        check("reset rdata", mem_rdata, 32'h0);
        check("reset err",   {31'b0, mem_err}, 32'h0);

        do_req(32'h005A_0000, 4'b0100, 1, 1'b0, "single write");
        check("slave C after write", {24'b0, slv_regs[2]}, 32'h5A);
        do_req(32'h0F00_A533, 4'b1111, 1, 1'b0, "full write");
        do_req(32'h0000_3C00, 4'b0110, 1, 1'b0, "set S C");
        do_req(32'h0, 4'b0000, 1, 1'b0, "read all");
        do_req($urandom, 4'b1010, 1, 1'b0, "gapped strobe");
        do_req($urandom, 4'b1000, TIMEOUT - 1, 1'b0, "ack at expiry");

        for (int k = 0; k < 10; k++)
            do_req($urandom, 4'($urandom), int'($urandom_range(1, 3)), 1'b0, $sformatf("random %0d", k));

        r0 = ready_cnt;
        c0 = stb_cyc;
        @(negedge clk);
        spur_ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        spur_ack = 1'b0;
        @(posedge clk);
        #1;
        check("spurious ack ready", ready_cnt - r0, 0);
        check("spurious ack stb",   stb_cyc - c0, 0);

        no_ack = 1'b1;
        do_req(32'h0, 4'b0000, 1, 1'b1, "timeout read");
        no_ack = 1'b0;
        c0 = stb_cyc;
        repeat (5) @(posedge clk);
        #1;
        check("no wb after timeout", stb_cyc - c0, 0);
        check("rdata held", mem_rdata, 32'hFFFF_FFFF);
        check("err held",   {31'b0, mem_err}, 32'h1);

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle reset stb",   {31'b0, wb_if.stb}, 32'h0);
        check("idle reset ready", {31'b0, mem_ready}, 32'h0);
        check("idle reset rdata", mem_rdata, 32'h0);
        check("idle reset err",   {31'b0, mem_err}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Abort a full write while lane 1 is on the bus; only lane 0 reached the slave.
        w = $urandom;
        ack_delay = 1;
        got_q.delete();
        r0 = ready_cnt;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_wdata = w;
        mem_wstrb = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 50; c++) begin
            if (wb_if.stb && wb_if.adr == 2'd1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("reached lane1", found, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort stb low", {31'b0, wb_if.stb}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort no ready", ready_cnt - r0, 0);
        check("abort wb cycles", got_q.size(), 1);
        exp_regs[0] = w[7:0];
        do_req(32'h0, 4'b0000, 1, 1'b0, "read after abort");

        for (int i = 0; i < 4; i++)
            check($sformatf("slave reg %0d", i), {24'b0, slv_regs[i]}, {24'b0, exp_regs[i]});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
